// File: rtl/mul_unit_pipe_pkg.sv
// rtl/mul_unit_pipe_pkg.sv - shared encodings and control payload for the pipelined multiplier
// Purpose: func3 encodings of the multiply group and the per-stage control
//          record that travels alongside each op (the tag and accumulator are
//          carried next to it because their widths are module parameters).
// Ports:   none (package)
package mul_unit_pipe_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;

  typedef struct packed {
    logic       neg;     // product of the magnitudes must be negated
    logic [2:0] func3;
    logic       int_32;  // word op
  } mul_ctrl_t;

endpackage

// File: rtl/mul_pp_stage.sv
// rtl/mul_pp_stage.sv - one partial-product accumulate stage of the pipelined multiplier
// Purpose: multiplies an unsigned magnitude by one CW-bit chunk of the second
//          magnitude (the chunk starting at bit SHIFT), shifts the partial
//          product into place and adds it to the incoming accumulator.
// Ports:   clk_i, rstn_i   clock, synchronous active-low reset
//          load_en_i       register the new accumulator (pipeline advance)
//          mag_i           first operand magnitude (XLEN)
//          mag2_i          full second operand magnitude (XLEN)
//          acc_i           accumulator from the previous stage (2*XLEN)
//          acc_o           registered accumulator (2*XLEN)
module mul_pp_stage #(
  parameter int XLEN  = 64,
  parameter int CW    = 32,
  parameter int SHIFT = 0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                load_en_i,
  input  logic [XLEN-1:0]     mag_i,
  input  logic [XLEN-1:0]     mag2_i,
  input  logic [2*XLEN-1:0]   acc_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [CW-1:0]     chunk;
  logic [2*XLEN-1:0] pp;

  assign chunk = CW'(mag2_i >> SHIFT);
  // Full 2*XLEN product; bits pushed past the top by the shift are always
  // zero because the final product of two XLEN magnitudes fits in 2*XLEN.
  assign pp = ({{XLEN{1'b0}}, mag_i} * {{(2*XLEN-CW){1'b0}}, chunk}) << SHIFT;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      acc_o <= '0;
    end else if (load_en_i) begin
      acc_o <= acc_i + pp;
    end
  end

endmodule

// File: rtl/mul_unit_pipe.sv
// rtl/mul_unit_pipe.sv - fully pipelined MUL/MULH/MULHSU/MULHU/MULW unit
// Purpose: accepts one op per cycle with a fixed latency of NUM_STAGES cycles.
//          Stage 1 converts operands to magnitudes plus a negate flag, stages
//          2..NUM_STAGES accumulate partial products, and the output side
//          negates and selects the result word. Whole pipe stalls on writeback
//          back-pressure; kill_i flushes every in-flight op.
// Ports:   clk_i, rstn_i           clock, synchronous active-low reset
//          kill_i                  flush all in-flight ops
//          valid_i/ready_o         request handshake (ready_o combinational)
//          func3_i, int_32_i       operation select
//          src1_i, src2_i, tag_i   operands and tag
//          valid_o/ready_i         result handshake
//          result_o, tag_o         result and its tag, zero when valid_o=0
module mul_unit_pipe
  import mul_unit_pipe_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int NUM_STAGES = 3,
  parameter int TAG_W      = 6
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              kill_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        func3_i,
  input  logic              int_32_i,
  input  logic [XLEN-1:0]   src1_i,
  input  logic [XLEN-1:0]   src2_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int NACC = NUM_STAGES - 1;   // accumulate stages
  localparam int CW   = XLEN / NACC;      // src2 chunk per stage

  logic adv;

  // Operand conditioning
  logic            sgn1, sgn2;
  logic [XLEN-1:0] op1, op2, mag1_d, mag2_d;
  mul_ctrl_t       ctrl_d;

  // Pipeline registers; position 0 is the conditioning register, position
  // NACC is the last accumulate stage which drives the outputs.
  logic [NACC:0]                  vld_q;
  mul_ctrl_t [NACC:0]             ctrl_q;
  logic [NACC:0][TAG_W-1:0]       tag_q;
  logic [NACC-1:0][XLEN-1:0]      mag1_q, mag2_q;
  logic [NACC-1:0][2*XLEN-1:0]    acc_q;

  logic [2*XLEN-1:0] sprod;

  assign valid_o = vld_q[NACC];
  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;

  always_comb begin
    op1 = src1_i;
    op2 = src2_i;
    if (int_32_i) begin
      // Word ops work on the sign-extended low halves, so the sign bit seen
      // below is bit 31 of the source.
      op1 = XLEN'(signed'(src1_i[31:0]));
      op2 = XLEN'(signed'(src2_i[31:0]));
    end
    sgn1 = op1[XLEN-1] & (func3_i == MUL_F3 || func3_i == MULH_F3 || func3_i == MULHSU_F3);
    sgn2 = op2[XLEN-1] & (func3_i == MUL_F3 || func3_i == MULH_F3);
    // Negating the most negative value yields 2^(XLEN-1), which is the
    // correct magnitude when read as unsigned.
    mag1_d        = sgn1 ? -op1 : op1;
    mag2_d        = sgn2 ? -op2 : op2;
    ctrl_d.neg    = sgn1 ^ sgn2;
    ctrl_d.func3  = func3_i;
    ctrl_d.int_32 = int_32_i;
  end

  // Valid chain: kill wins over advance, so a flush clears even a stalled pipe.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      vld_q <= '0;
    end else if (kill_i) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[NACC-1:0], valid_i};
    end
  end

  // Payload needs no reset: everything leaving the unit is gated by valid.
  always_ff @(posedge clk_i) begin
    if (adv) begin
      ctrl_q[0] <= ctrl_d;
      tag_q[0]  <= tag_i;
      mag1_q[0] <= mag1_d;
      mag2_q[0] <= mag2_d;
      for (int k = 1; k <= NACC; k++) begin
        ctrl_q[k] <= ctrl_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
      for (int k = 1; k < NACC; k++) begin
        mag1_q[k] <= mag1_q[k-1];
        mag2_q[k] <= mag2_q[k-1];
      end
    end
  end

  for (genvar g = 0; g < NACC; g++) begin : g_acc
    if (g == 0) begin : g_first
      mul_pp_stage #(.XLEN(XLEN), .CW(CW), .SHIFT(0)) u_stage (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .load_en_i (adv),
        .mag_i     (mag1_q[0]),
        .mag2_i    (mag2_q[0]),
        .acc_i     ('0),
        .acc_o     (acc_q[0])
      );
    end else begin : g_next
      mul_pp_stage #(.XLEN(XLEN), .CW(CW), .SHIFT(g*CW)) u_stage (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .load_en_i (adv),
        .mag_i     (mag1_q[g]),
        .mag2_i    (mag2_q[g]),
        .acc_i     (acc_q[g-1]),
        .acc_o     (acc_q[g])
      );
    end
  end

  assign sprod = ctrl_q[NACC].neg ? -acc_q[NACC-1] : acc_q[NACC-1];
  assign tag_o = valid_o ? tag_q[NACC] : '0;

  // Result select; illegal encodings still flow through but return zero.
  always_comb begin
    result_o = '0;
    if (valid_o) begin
      if (ctrl_q[NACC].int_32) begin
        if (ctrl_q[NACC].func3 == MUL_F3) begin
          result_o = XLEN'(signed'(sprod[31:0]));
        end
      end else begin
        case (ctrl_q[NACC].func3)
          MUL_F3:                       result_o = sprod[XLEN-1:0];
          MULH_F3, MULHSU_F3, MULHU_F3: result_o = sprod[2*XLEN-1:XLEN];
          default:                      result_o = '0;
        endcase
      end
    end
  end

endmodule
